ysyx_22040127_mem_arbiter: RTL
==============================

Name: ysyx_22040127_mem_arbiter

Overview:
- Shares the core's single physical-memory port between instruction fetch (IF, read-only) and load/store unit (LSU, read/write).
- Sits between the multi-cycle fetch/LSU stages and the pmem bridge, and replaces the direct combinational pmem_read/write paths.
- Round-robin arbitration, one outstanding transaction, registered responses, watchdog timeout with error response.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width (doubleword bus).
- TIMEOUT, 255, max cycles spent in ISSUE+WAIT before abort (1..65535).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_resp_valid  out  1  fetch response pulse
- if_resp_data  out  DATA_W  fetched doubleword
- if_resp_err  out  1  fetch timed out
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted
- ls_req_addr  in  ADDR_W  LSU address
- ls_req_wen  in  1  1=store, 0=load
- ls_req_wdata  in  DATA_W  store data
- ls_req_wmask  in  DATA_W/8  byte enables
- ls_resp_valid  out  1  LSU response pulse
- ls_resp_data  out  DATA_W  load data (0 for stores)
- ls_resp_err  out  1  LSU timed out
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W
- mem_req_wen  out  1
- mem_req_wdata  out  DATA_W
- mem_req_wmask  out  DATA_W/8  (all-ones for IF reads)
- mem_resp_valid  in  1  memory response (returned for reads and writes)
- mem_resp_data  in  DATA_W
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state=IDLE, last_grant=IF, timeout counter=0, latched request cleared. Reset mid-transaction drops it; no response is produced.
- States: IDLE, ISSUE, WAIT.
- IDLE arbitration (combinational *_req_ready, asserted only in IDLE):
  - Only one valid: that requester wins.
  - Both valid: the one not equal to last_grant wins, so the first contention after reset goes to LSU.
  - Winner's req_ready=1 and the other's=0. On acceptance, latch addr/wen/wdata/wmask/owner, set last_grant=owner, go to ISSUE.
  - IF request latches wen=0, wmask=all-ones, wdata=0.
- ISSUE: mem_req_valid=1 with latched fields, held stable until mem_req_ready. On handshake go to WAIT.
- WAIT: mem_req_valid=0. On mem_resp_valid, register the response to the owner: next cycle owner resp_valid=1 for exactly one cycle, resp_data=mem_resp_data (LSU store: 0), err=0. State is IDLE in that same cycle, so a new request can be accepted in the response cycle.
- Latency: accept at T, mem_req_valid at T+1; if ready at T+1 and mem_resp_valid at T+2, resp_valid is at T+3. Minimum accept-to-accept is 3 cycles.
- Timeout:
  - Counter clears on accept and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT without completion, abort: owner resp_valid=1, err=1, data=0; go to IDLE.
- mem_resp_valid outside WAIT is ignored (late response after timeout is discarded).
- Non-owner resp_valid is never asserted. resp_data/err are held from the last response when resp_valid=0.
- Requesters must hold req fields stable while valid and not ready. Dropping valid before ready is permitted and cancels the request.
- Simultaneous mem_req_ready and timeout expiry in ISSUE: the handshake wins and the state goes to WAIT.
- Simultaneous mem_resp_valid and timeout expiry in WAIT: the response wins and err=0.

Test Plan:
- Reset, then IF-only read at 0x80000000; memory ready immediately, response data 0x0000_0013_0000_0297 one cycle later -> if_resp_valid pulses at T+3 with that data, err=0, ls_resp_valid stays 0.
- Both valid in the same cycle after reset -> ls_req_ready=1, if_req_ready=0. IF is granted on the next IDLE. With both held valid continuously, grants alternate LSU, IF, LSU, IF.
- LSU store addr 0x80001008, wdata 0xDEADBEEF_CAFEF00D, wmask 0x0F; mem_req_ready held low 4 cycles -> mem_req fields stable throughout, mem_req_wen=1, ls_resp_data=0 on response.
- TIMEOUT=8, memory never responds -> ls_resp_valid=1, ls_resp_err=1 exactly 8 cycles after accept. A late mem_resp_valid in IDLE produces no response.
- rst asserted while in WAIT -> next cycle all outputs 0, busy=0. A subsequent mem_resp_valid is ignored and a new IF request is accepted normally.
- Back-to-back: new IF valid during the response cycle -> accepted in that cycle, mem_req_valid the next cycle.

Source files
------------

// File: rtl/ysyx_22040127_mem_arbiter.sv
// Round-robin arbiter sharing the single pmem port between instruction fetch and LSU.
// One outstanding transaction, registered responses, watchdog abort with error response.
module ysyx_22040127_mem_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t              state_q, state_d;
  owner_t              last_grant_q, owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [15:0]         cnt_q;
  logic                grant_if, grant_ls, accept, expire, done, abort;

  // On contention the requester that did not win last time gets the port.
  assign grant_ls = ls_req_valid && (!if_req_valid || last_grant_q == OWN_IF);
  assign grant_if = if_req_valid && (!ls_req_valid || last_grant_q == OWN_LS);
  assign accept   = (state_q == IDLE) && (grant_if || grant_ls);

  // cnt_q holds the ISSUE/WAIT cycles already spent; the abort is decided one cycle
  // early so the registered error response lands exactly TIMEOUT cycles after accept.
  assign expire = ({1'b0, cnt_q} + 17'd2) >= 17'(TIMEOUT);
  assign done   = (state_q == WAIT) && mem_resp_valid;
  assign abort  = ((state_q == ISSUE) && !mem_req_ready && expire) ||
                  ((state_q == WAIT)  && !mem_resp_valid && expire);

  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_if || grant_ls)  state_d = ISSUE;
      ISSUE:   if (mem_req_ready)         state_d = WAIT;
               else if (expire)           state_d = IDLE;
      WAIT:    if (mem_resp_valid || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_req_ready  = !rst && (state_q == IDLE) && grant_if;
    ls_req_ready  = !rst && (state_q == IDLE) && grant_ls;
    mem_req_valid = (state_q == ISSUE);
    busy          = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= OWN_IF;
      owner_q       <= OWN_IF;
      addr_q        <= '0;
      wen_q         <= 1'b0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      cnt_q         <= '0;
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      if_resp_err   <= 1'b0;
      ls_resp_valid <= 1'b0;
      ls_resp_data  <= '0;
      ls_resp_err   <= 1'b0;
    end else begin
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      if (accept) begin
        owner_q      <= grant_ls ? OWN_LS : OWN_IF;
        last_grant_q <= grant_ls ? OWN_LS : OWN_IF;
        addr_q       <= grant_ls ? ls_req_addr : if_req_addr;
        wen_q        <= grant_ls && ls_req_wen;
        wdata_q      <= grant_ls ? ls_req_wdata : '0;
        wmask_q      <= grant_ls ? ls_req_wmask : '1;
        cnt_q        <= '0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (done || abort) begin
        if (owner_q == OWN_LS) begin
          ls_resp_valid <= 1'b1;
          ls_resp_data  <= (abort || wen_q) ? '0 : mem_resp_data;
          ls_resp_err   <= abort;
        end else begin
          if_resp_valid <= 1'b1;
          if_resp_data  <= abort ? '0 : mem_resp_data;
          if_resp_err   <= abort;
        end
      end
    end
  end

endmodule
